bus_initiator: RTL and testbench
================================

Name: bus_initiator

Overview:
- Bus master port that turns single load/store requests from the core's LSU into `bus_*` read/write cycles.
- Those cycles drive memory-mapped responders such as the CLINT (msip 0x0, mtimecmp 0x4000, mtime 0xbff8).
- Splits 8-byte accesses into two 4-byte beats and collects registered read data after a fixed latency.
- Returns one response per request over a valid/ready handshake.

Parameters:
- READ_LATENCY, 1: cycles from bus rd assertion to valid responder read data (1..3).
- SPLIT_BEAT_BYTES, 4: bytes per bus beat when an 8-byte request is split.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset (rst==0 resets on posedge clk)
- req_valid  in  1  LSU request valid
- req_ready  out  1  initiator can accept a request
- req_addr  in  `ADDR_WIDTH  byte address
- req_size  in  `SIZE_WIDTH  access bytes: 1, 2, 4 or 8
- req_write  in  1  1=store, 0=load
- req_wdata  in  2*`REG_DATA_WIDTH  store data, low bytes first
- resp_valid  out  1  response valid
- resp_ready  in  1  LSU accepts response
- resp_rdata  out  2*`REG_DATA_WIDTH  load data, zero-extended; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size, no bus cycle issued
- bus_read_addr  out  `ADDR_WIDTH  beat read address
- bus_write_addr  out  `ADDR_WIDTH  beat write address
- bus_read_size  out  `SIZE_WIDTH  beat read size
- bus_write_size  out  `SIZE_WIDTH  beat write size
- bus_data  out  `REG_DATA_WIDTH  beat write data
- bus_rd  out  1  read strobe, one cycle per beat
- bus_wr  out  1  write strobe, one cycle per beat
- bus_rdata  in  `BUS_DATA_WIDTH  responder read data, valid READ_LATENCY cycles after bus_rd

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; bus_rd=bus_wr=0; all bus address/size/data outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready in cycle A.
  - Illegal size (not 1/2/4/8) or addr not naturally aligned -> RESP in A+1 with resp_err=1, no strobe.
  - Otherwise -> ISSUE.
- ISSUE, beat 0 in cycle A+1:
  - Store: bus_wr=1, bus_write_addr=req_addr, bus_write_size=min(size,4), bus_data=wdata[31:0].
  - Load: bus_rd=1, bus_read_addr=req_addr, bus_read_size=min(size,4).
  - Size 8: beat 1 in A+2 at addr+4. Stores take data wdata[63:32]. Beats are back-to-back with no gap.
- Strobes last exactly one cycle per beat. Address/size/data are valid only while the strobe is high; otherwise 0.
- Stores: after the last beat -> RESP. resp_valid rises the cycle after the last bus_wr.
- Loads:
  - A per-beat valid/tag shift register of depth READ_LATENCY marks which cycle's bus_rdata belongs to which beat.
  - Beat 0 data goes to rdata[31:0] and beat 1 data to rdata[63:32], registered at the end of the capture cycle.
  - Sizes 1 and 2 mask to the low 8 or 16 bits.
  - State WAIT until the last beat is captured, then RESP. resp_valid rises the cycle after the last capture.
  - 4-byte load, L=1: rd in A+1, capture in A+2, resp_valid from A+3.
  - 8-byte load, L=1: resp_valid from A+4.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid&&resp_ready. Then -> IDLE.
  - req_ready is 0 in every state except IDLE. No same-cycle response/accept turnaround, so the next request is accepted at the earliest one cycle after the response handshake.
- req_* signals are captured at accept. Later changes to req_* do not affect the in-flight transaction.
- Reset mid-operation: the in-flight transaction is dropped, no response is produced, and strobes are 0 from the next cycle. A split store may have completed only beat 0; the LSU reissues it.
- bus_rdata is ignored in cycles without a pending capture tag.

Decomposition:
- Shared package bus_pkg:
  - state enum bus_initiator_state_t {IDLE, ISSUE, WAIT, RESP};
  - size encodings SIZE_B=1, SIZE_H=2, SIZE_W=4, SIZE_D=8;
  - alignment-check function.
- Widths come from the existing config.svh/common.svh macros.
- One natural sub-module: bus_read_tracker, the READ_LATENCY-deep tag shift register with beat index.

Test Plan:
- Store 0x4000, size 4, data 0x1 -> bus_wr=1 one cycle at A+1, write_addr=0x4000, bus_data=0x1; resp_valid at A+2, err=0; a follow-up load at 0x4000 returns 0x1.
- Store 0x4000, size 8, data 0x00000001_00000010 -> bus_wr in A+1 (0x4000, 0x10) and A+2 (0x4004, 0x1); one response only.
- Load 0xbff8, size 8, L=1 -> bus_rd A+1 (0xbff8) and A+2 (0xbffc); resp_rdata={hi,lo} captured A+2/A+3; resp_valid at A+4.
- Load 0x4002, size 4 and size 3 -> resp_err=1 at A+1, rdata=0, no bus_rd/bus_wr ever asserted.
- resp_ready held low 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout; after the handshake, req_ready=1 the next cycle.
- rst=0 asserted in the WAIT cycle of an 8-byte load -> no resp_valid, outputs at reset values, next request executes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types, widths and access helpers for the LSU-side bus initiator.
// Widths mirror the core configuration: 32-bit addresses and 32-bit bus beats.
package bus_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int SIZE_WIDTH     = 4;
    localparam int REG_DATA_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } bus_initiator_state_t;

    localparam logic [SIZE_WIDTH-1:0] SIZE_B = 4'd1;
    localparam logic [SIZE_WIDTH-1:0] SIZE_H = 4'd2;
    localparam logic [SIZE_WIDTH-1:0] SIZE_W = 4'd4;
    localparam logic [SIZE_WIDTH-1:0] SIZE_D = 4'd8;

    // Legal size and natural alignment; anything else is answered with an error.
    function automatic logic is_legal_access(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [SIZE_WIDTH-1:0] size);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = (addr[0] == 1'b0);
            SIZE_W:  ok = (addr[1:0] == 2'b00);
            SIZE_D:  ok = (addr[2:0] == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [REG_DATA_WIDTH-1:0] mask_read_data(
        input logic [SIZE_WIDTH-1:0]     size,
        input logic [REG_DATA_WIDTH-1:0] data);
        logic [REG_DATA_WIDTH-1:0] res;
        case (size)
            SIZE_B:  res = {{(REG_DATA_WIDTH-8){1'b0}}, data[7:0]};
            SIZE_H:  res = {{(REG_DATA_WIDTH-16){1'b0}}, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bus_read_tracker.sv
// Tag pipeline that follows each read strobe for READ_LATENCY cycles so the
// initiator knows which beat the responder data belongs to.
module bus_read_tracker
    import bus_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_beat,
    input  logic i_last,
    output logic o_cap_valid,
    output logic o_cap_beat,
    output logic o_cap_last
);

    logic [READ_LATENCY-1:0] r_valid;
    logic [READ_LATENCY-1:0] r_beat;
    logic [READ_LATENCY-1:0] r_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_beat  <= '0;
            r_last  <= '0;
        end else begin
            r_valid[0] <= i_push;
            r_beat[0]  <= i_push & i_beat;
            r_last[0]  <= i_push & i_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_beat[i]  <= r_beat[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    assign o_cap_valid = r_valid[READ_LATENCY-1];
    assign o_cap_beat  = r_beat[READ_LATENCY-1];
    assign o_cap_last  = r_last[READ_LATENCY-1];

endmodule

// File: rtl/bus_initiator.sv
// LSU-to-bus master: one load/store request in, one or two bus beats out,
// one response back. 8-byte accesses are split into two back-to-back beats.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | driving a read or write strobe for the current beat
// WAIT  | read beats outstanding, waiting for the last capture
// RESP  | response presented, held until the LSU takes it
module bus_initiator
    import bus_pkg::*;
#(
    parameter int READ_LATENCY     = 1,
    parameter int SPLIT_BEAT_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [SIZE_WIDTH-1:0]         req_size,
    input  logic                          req_write,
    input  logic [2*REG_DATA_WIDTH-1:0]   req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [2*REG_DATA_WIDTH-1:0]   resp_rdata,
    output logic                          resp_err,
    output logic [ADDR_WIDTH-1:0]         bus_read_addr,
    output logic [ADDR_WIDTH-1:0]         bus_write_addr,
    output logic [SIZE_WIDTH-1:0]         bus_read_size,
    output logic [SIZE_WIDTH-1:0]         bus_write_size,
    output logic [REG_DATA_WIDTH-1:0]     bus_data,
    output logic                          bus_rd,
    output logic                          bus_wr,
    input  logic [BUS_DATA_WIDTH-1:0]     bus_rdata
);

    localparam logic [SIZE_WIDTH-1:0] LP_BEAT_SIZE = SIZE_WIDTH'(SPLIT_BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LP_BEAT_OFFS = ADDR_WIDTH'(SPLIT_BEAT_BYTES);

    bus_initiator_state_t r_state;
    bus_initiator_state_t w_next_state;

    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [SIZE_WIDTH-1:0]       r_size;
    logic                        r_write;
    logic [2*REG_DATA_WIDTH-1:0] r_wdata;
    logic                        r_beat;
    logic [2*REG_DATA_WIDTH-1:0] r_rdata;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_legal;
    logic                        w_last_beat;
    logic [ADDR_WIDTH-1:0]       w_beat_addr;
    logic [SIZE_WIDTH-1:0]       w_beat_size;
    logic [REG_DATA_WIDTH-1:0]   w_beat_data;
    logic [REG_DATA_WIDTH-1:0]   w_rdata_word;
    logic                        w_cap_valid;
    logic                        w_cap_beat;
    logic                        w_cap_last;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_legal      = is_legal_access(req_addr, req_size);
    assign w_last_beat  = (r_size != SIZE_D) || r_beat;
    assign w_beat_addr  = r_addr + (r_beat ? LP_BEAT_OFFS : '0);
    assign w_beat_size  = (r_size > LP_BEAT_SIZE) ? LP_BEAT_SIZE : r_size;
    assign w_beat_data  = r_beat ? r_wdata[2*REG_DATA_WIDTH-1:REG_DATA_WIDTH]
                                 : r_wdata[REG_DATA_WIDTH-1:0];
    assign w_rdata_word = REG_DATA_WIDTH'(bus_rdata);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_err       = 1'b0;
        bus_rd         = 1'b0;
        bus_wr         = 1'b0;
        bus_read_addr  = '0;
        bus_write_addr = '0;
        bus_read_size  = '0;
        bus_write_size = '0;
        bus_data       = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (r_write) begin
                    bus_wr         = 1'b1;
                    bus_write_addr = w_beat_addr;
                    bus_write_size = w_beat_size;
                    bus_data       = w_beat_data;
                end else begin
                    bus_rd        = 1'b1;
                    bus_read_addr = w_beat_addr;
                    bus_read_size = w_beat_size;
                end
                if (w_last_beat) begin
                    w_next_state = r_write ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (w_cap_valid && w_cap_last) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_err   = r_err;
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request fields are frozen at accept so the LSU may move on immediately.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_beat  <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_write <= req_write;
                r_wdata <= req_wdata;
                r_beat  <= 1'b0;
                r_rdata <= '0;
                r_err   <= !w_legal;
            end
            if ((r_state == ISSUE) && !w_last_beat) begin
                r_beat <= 1'b1;
            end
            if (w_cap_valid) begin
                if (w_cap_beat) begin
                    r_rdata[2*REG_DATA_WIDTH-1:REG_DATA_WIDTH] <= w_rdata_word;
                end else begin
                    r_rdata[REG_DATA_WIDTH-1:0] <= mask_read_data(r_size, w_rdata_word);
                end
            end
        end
    end

    bus_read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_push      (bus_rd),
        .i_beat      (r_beat),
        .i_last      (w_last_beat),
        .o_cap_valid (w_cap_valid),
        .o_cap_beat  (w_cap_beat),
        .o_cap_last  (w_cap_last)
    );

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed vector table, reset-in-flight sequence and
// randomized requests checked against a request-level memory model.
module tb_bus_initiator;
    import bus_pkg::*;

    localparam int RL = 1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_size;
    logic        req_write;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [31:0] bus_read_addr;
    logic [31:0] bus_write_addr;
    logic [3:0]  bus_read_size;
    logic [3:0]  bus_write_size;
    logic [31:0] bus_data;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    bus_initiator #(.READ_LATENCY(RL), .SPLIT_BEAT_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_write(req_write), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_read_addr(bus_read_addr), .bus_write_addr(bus_write_addr),
        .bus_read_size(bus_read_size), .bus_write_size(bus_write_size),
        .bus_data(bus_data), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default content of any word never written.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Responder: word-indexed memory, read data valid RL cycles after bus_rd,
    // random junk on bus_rdata in all other cycles.
    logic [31:0] bus_mem  [0:16383];
    bit          bus_wflg [0:16383];
    logic [31:0] rsp_pipe [0:RL-1];

    always @(posedge clk) begin
        if (bus_wr) begin
            bus_mem[bus_write_addr[15:2]]  <= bus_data;
            bus_wflg[bus_write_addr[15:2]] <= 1'b1;
        end
        if (bus_rd)
            rsp_pipe[0] <= bus_wflg[bus_read_addr[15:2]] ? bus_mem[bus_read_addr[15:2]]
                                                         : init_word({16'h0, bus_read_addr[15:2], 2'b00});
        else
            rsp_pipe[0] <= $urandom;
        for (int i = 1; i < RL; i++) rsp_pipe[i] <= rsp_pipe[i-1];
    end
    assign bus_rdata = rsp_pipe[RL-1];

    // Reference memory seen from the request side.
    logic [31:0] ref_mem [0:16383];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  size;
        bit          wr;
        logic [63:0] wdata;
        bit          exp_err;
        int          exp_lat;
        logic [63:0] exp_rdata;
        int          hold;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  size;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: expected response of a request from the access rules alone.
    function automatic vec_t model(input logic [31:0] addr, input logic [3:0] size,
                                   input bit wr, input logic [63:0] wdata, input int hold);
        vec_t v;
        int   nb;
        logic [31:0] lo, hi;
        v.addr = addr; v.size = size; v.wr = wr; v.wdata = wdata; v.hold = hold;
        v.exp_rdata = 64'h0;
        v.exp_err = !((size == 1 || size == 2 || size == 4 || size == 8) && (addr % size == 0));
        nb = (size == 8) ? 2 : 1;
        if (v.exp_err) v.exp_lat = 1;
        else if (wr)   v.exp_lat = nb + 1;
        else begin
            v.exp_lat = nb + RL + 1;
            lo = ref_mem[(addr / 4) % 16384];
            hi = ref_mem[((addr + 4) / 4) % 16384];
            if (size == 1)      v.exp_rdata = {32'h0, lo % 256};
            else if (size == 2) v.exp_rdata = {32'h0, lo % 65536};
            else if (size == 4) v.exp_rdata = {32'h0, lo};
            else                v.exp_rdata = {hi, lo};
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        beat_t obs[$];
        beat_t exp_q[$];
        beat_t b;
        int    got_lat = -1;
        bit    bad_ready = 0, bad_idle_bus = 0, bad_hold = 0;
        logic [63:0] hold_rdata;
        logic        hold_err;
        int    nb;

        if (!v.exp_err) begin
            nb = (v.size == 8) ? 2 : 1;
            for (int i = 0; i < nb; i++) begin
                b.wr   = v.wr;
                b.addr = v.addr + 32'(4 * i);
                b.size = (v.size > 4) ? 4'd4 : v.size;
                b.data = v.wr ? ((i == 1) ? v.wdata[63:32] : v.wdata[31:0]) : 32'h0;
                b.cyc  = 1 + i;
                exp_q.push_back(b);
            end
        end

        check({tag, " req_ready_idle"}, {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1; req_addr = v.addr; req_size = v.size;
        req_write = v.wr; req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        req_addr = $urandom; req_size = 4'($urandom); req_write = 1'($urandom);
        req_wdata = {$urandom, $urandom};

        for (int k = 1; k <= 12 && got_lat < 0; k++) begin
            if (req_ready) bad_ready = 1;
            if (bus_rd) begin
                b.wr = 0; b.addr = bus_read_addr; b.size = bus_read_size; b.data = 32'h0; b.cyc = k;
                obs.push_back(b);
            end else if (bus_read_addr != 0 || bus_read_size != 0) bad_idle_bus = 1;
            if (bus_wr) begin
                b.wr = 1; b.addr = bus_write_addr; b.size = bus_write_size; b.data = bus_data; b.cyc = k;
                obs.push_back(b);
            end else if (bus_write_addr != 0 || bus_write_size != 0 || bus_data != 0) bad_idle_bus = 1;
            if (resp_valid) got_lat = k;
            else tick();
        end

        check({tag, " resp_latency"}, 64'(got_lat), 64'(v.exp_lat));
        check({tag, " resp_err"}, {63'h0, resp_err}, {63'h0, v.exp_err});
        check({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
        check({tag, " beat_count"}, 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check({tag, " beat_kind_cycle"}, {31'h0, obs[i].wr, 32'(obs[i].cyc)},
                  {31'h0, exp_q[i].wr, 32'(exp_q[i].cyc)});
            check({tag, " beat_addr"}, {32'h0, obs[i].addr}, {32'h0, exp_q[i].addr});
            check({tag, " beat_size_data"}, {28'h0, obs[i].size, obs[i].data},
                  {28'h0, exp_q[i].size, exp_q[i].data});
        end
        check({tag, " busy_req_ready_low"}, {63'h0, bad_ready}, 64'h0);
        check({tag, " idle_bus_zero"}, {63'h0, bad_idle_bus}, 64'h0);

        hold_rdata = resp_rdata;
        hold_err   = resp_err;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_rdata !== hold_rdata || resp_err !== hold_err || req_ready !== 1'b0)
                bad_hold = 1;
        end
        if (v.hold > 0) check({tag, " resp_hold_stable"}, {63'h0, bad_hold}, 64'h0);

        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, " post_handshake"}, {62'h0, req_ready, resp_valid}, 64'h2);

        if (v.wr && !v.exp_err) begin
            ref_mem[(v.addr / 4) % 16384] = v.wdata[31:0];
            if (v.size == 8) ref_mem[((v.addr + 4) / 4) % 16384] = v.wdata[63:32];
        end
    endtask

    vec_t table_v[$];
    vec_t v;

    task automatic add(input logic [31:0] a, input logic [3:0] s, input bit w, input logic [63:0] d,
                       input bit e, input int lat, input logic [63:0] rd, input int hold);
        vec_t t;
        t.addr = a; t.size = s; t.wr = w; t.wdata = d;
        t.exp_err = e; t.exp_lat = lat; t.exp_rdata = rd; t.hold = hold;
        table_v.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [6];
        logic [3:0]  sizes [8];
        bit          bad_rst;

        for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(32'(i * 4));
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_write = 1'b0;
        req_wdata = '0; resp_ready = 1'b0;
        repeat (3) tick();
        check("reset ready_valid_err", {61'h0, req_ready, resp_valid, resp_err}, 64'h4);
        check("reset strobes_rdata", {resp_rdata[61:0], bus_rd, bus_wr}, 64'h0);
        check("reset bus_outputs", {bus_read_addr, bus_write_addr} | {24'h0, bus_read_size, bus_write_size, bus_data},
              64'h0);
        rst = 1'b1;
        tick();

        // Directed table (latencies for RL = 1).
        add(32'h4000, 4'd4, 1, 64'h0000_0000_0000_0001, 0, 2, 64'h0, 0);
        add(32'h4000, 4'd4, 0, 64'h0,                   0, 3, 64'h1, 0);
        add(32'h4000, 4'd8, 1, 64'h0000_0001_0000_0010, 0, 3, 64'h0, 1);
        add(32'h4000, 4'd4, 0, 64'h0,                   0, 3, 64'h10, 0);
        add(32'h4004, 4'd4, 0, 64'h0,                   0, 3, 64'h1, 0);
        add(32'hbff8, 4'd8, 1, 64'h1234_5678_9ABC_DEF0, 0, 3, 64'h0, 0);
        add(32'hbff8, 4'd8, 0, 64'h0,                   0, 4, 64'h1234_5678_9ABC_DEF0, 5);
        add(32'h4002, 4'd4, 0, 64'h0,                   1, 1, 64'h0, 0);
        add(32'h4000, 4'd3, 0, 64'h0,                   1, 1, 64'h0, 2);
        add(32'h0004, 4'd8, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h0, 0);
        add(32'h0000, 4'd4, 1, 64'h0000_0000_CAFE_BEEF, 0, 2, 64'h0, 0);
        add(32'h0000, 4'd1, 0, 64'h0,                   0, 3, 64'hEF, 0);
        add(32'h0002, 4'd2, 0, 64'h0,                   0, 3, 64'hBEEF, 0);
        add(32'h0000, 4'd0, 0, 64'h0,                   1, 1, 64'h0, 0);
        foreach (table_v[i]) run_txn(table_v[i], $sformatf("vec%0d", i));

        // Reset while an 8-byte load is in WAIT.
        check("rst_seq ready", {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1; req_addr = 32'hbff8; req_size = 4'd8; req_write = 1'b0; req_wdata = '0;
        tick();
        req_valid = 1'b0;
        check("rst_seq beat0_rd", {31'h0, bus_rd, bus_read_addr}, {32'h1, 32'hbff8});
        tick();
        tick();
        check("rst_seq wait_no_resp", {62'h0, resp_valid, bus_rd}, 64'h0);
        rst = 1'b0;
        tick();
        check("rst_seq after_reset", {60'h0, req_ready, resp_valid, resp_err, bus_rd}, 64'h8);
        check("rst_seq rdata_zero", resp_rdata, 64'h0);
        rst = 1'b1;
        bad_rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid || bus_rd || bus_wr || !req_ready) bad_rst = 1;
        end
        check("rst_seq quiet_after", {63'h0, bad_rst}, 64'h0);
        v = model(32'hbff8, 4'd8, 0, 64'h0, 1);
        run_txn(v, "rst_seq reload");

        // Randomized requests against the model.
        pool[0] = 32'h0; pool[1] = 32'h8; pool[2] = 32'h4000;
        pool[3] = 32'h4008; pool[4] = 32'hbff8; pool[5] = 32'h100;
        sizes[0] = 4'd1; sizes[1] = 4'd2; sizes[2] = 4'd4; sizes[3] = 4'd8;
        sizes[4] = 4'd8; sizes[5] = 4'd4; sizes[6] = 4'd3; sizes[7] = 4'd0;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 7));
            v = model(a, sizes[$urandom_range(0, 7)], 1'($urandom), {$urandom, $urandom},
                      $urandom_range(0, 3));
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
